// File: rtl/sys_reset_seq.sv
// sys_reset_seq: system reset sequencer for the RV32I core.
// Synchronizes the JTAG reset request and DDR3 calibration-done level into clk,
// then holds core_reset until DDR is ready and all reset causes have been quiet
// for HOLD_CYCLES cycles. Counts resets issued while running (saturating).
module sys_reset_seq #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 jsys_reset,
   input  logic                 init_ddr3_done,
   input  logic                 soft_reset_req,
   output logic                 core_reset,
   output logic                 ddr_ready,
   output logic [1:0]           seq_state,
   output logic [CNT_WIDTH-1:0] reset_count
);

   typedef enum logic [1:0] {
      ST_WAIT_DDR = 2'd0,
      ST_HOLD     = 2'd1,
      ST_RUN      = 2'd2,
      ST_UNUSED   = 2'd3
   } state_t;

   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

   logic [SYNC_STAGES-1:0] jrst_sync_q, jrst_sync_d;
   logic [SYNC_STAGES-1:0] ddr_sync_q, ddr_sync_d;
   logic                   jrst_s, ddr_s, cause;
   state_t                 state_q, state_d;
   logic [7:0]             hold_cnt_q, hold_cnt_d;
   logic                   core_reset_q, core_reset_d;
   logic [CNT_WIDTH-1:0]   reset_count_q, reset_count_d;
   logic                   run_exit;

   // Synchronizer chains shift the raw asynchronous levels in at stage 0.
   always_comb begin
      jrst_sync_d = {jrst_sync_q[SYNC_STAGES-2:0], jsys_reset};
      ddr_sync_d  = {ddr_sync_q[SYNC_STAGES-2:0], init_ddr3_done};
   end

   // Synchronizer flops; the only place the asynchronous inputs are sampled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         jrst_sync_q <= '0;
         ddr_sync_q  <= '0;
      end else begin
         jrst_sync_q <= jrst_sync_d;
         ddr_sync_q  <= ddr_sync_d;
      end
   end

   assign jrst_s = jrst_sync_q[SYNC_STAGES-1];
   assign ddr_s  = ddr_sync_q[SYNC_STAGES-1];
   assign cause  = jrst_s | soft_reset_req;

   // State register together with the hold countdown it owns.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_WAIT_DDR;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   // Next-state logic: DDR loss dominates, then reset causes, then the countdown.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_WAIT_DDR: begin
            if (ddr_s) begin
               state_d    = ST_HOLD;
               hold_cnt_d = HOLD_LOAD;
            end
         end
         ST_HOLD: begin
            if (!ddr_s) begin
               state_d = ST_WAIT_DDR;
            end else if (cause) begin
               hold_cnt_d = HOLD_LOAD;
            end else if (hold_cnt_q == 8'd0) begin
               state_d = ST_RUN;
            end else begin
               hold_cnt_d = hold_cnt_q - 8'd1;
            end
         end
         ST_RUN: begin
            if (!ddr_s) begin
               state_d = ST_WAIT_DDR;
            end else if (cause) begin
               state_d    = ST_HOLD;
               hold_cnt_d = HOLD_LOAD;
            end
         end
         default: state_d = ST_WAIT_DDR;
      endcase
   end

   // Output logic: core_reset follows the registered state; RUN exits are counted once.
   always_comb begin
      core_reset_d  = (state_q != ST_RUN);
      run_exit      = (state_q == ST_RUN) && (state_d != ST_RUN);
      reset_count_d = reset_count_q;
      if (run_exit && !(&reset_count_q)) begin
         reset_count_d = reset_count_q + 1'b1;
      end
   end

   // Output flops so core_reset and reset_count have no combinational path out.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         core_reset_q  <= 1'b1;
         reset_count_q <= '0;
      end else begin
         core_reset_q  <= core_reset_d;
         reset_count_q <= reset_count_d;
      end
   end

   assign core_reset  = core_reset_q;
   assign ddr_ready   = ddr_s;
   assign seq_state   = state_q;
   assign reset_count = reset_count_q;

endmodule

// File: tb/tb_sys_reset_seq.sv
// Testbench for sys_reset_seq: directed scenarios plus randomized traffic,
// checked every cycle against a quiet-time reference model.
module tb_sys_reset_seq;

   localparam int SS   = 2;
   localparam int HC   = 16;
   localparam int CW   = 8;
   localparam int CMAX = (1 << CW) - 1;
   localparam int M_WAIT = 0;
   localparam int M_HOLD = 1;
   localparam int M_RUN  = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          jsys_reset = 1'b0;
   logic          init_ddr3_done = 1'b0;
   logic          soft_reset_req = 1'b0;
   logic          core_reset;
   logic          ddr_ready;
   logic [1:0]    seq_state;
   logic [CW-1:0] reset_count;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: mode, number of consecutive quiet HOLD cycles, exit count
   int m_mode  = M_WAIT;
   int m_quiet = 0;
   int m_count = 0;
   bit m_core  = 1'b1;
   bit m_jp[SS];
   bit m_dp[SS];

   sys_reset_seq #(.SYNC_STAGES(SS), .HOLD_CYCLES(HC), .CNT_WIDTH(CW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .jsys_reset     (jsys_reset),
      .init_ddr3_done (init_ddr3_done),
      .soft_reset_req (soft_reset_req),
      .core_reset     (core_reset),
      .ddr_ready      (ddr_ready),
      .seq_state      (seq_state),
      .reset_count    (reset_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock edge of the reference model, using the inputs present at the edge.
   task automatic model_step();
      bit jr, ds, cs;
      if (!rst_n) begin
         m_mode = M_WAIT; m_quiet = 0; m_count = 0; m_core = 1'b1;
         for (int i = 0; i < SS; i++) begin m_jp[i] = 1'b0; m_dp[i] = 1'b0; end
      end else begin
         jr = m_jp[SS-1];
         ds = m_dp[SS-1];
         cs = jr | soft_reset_req;
         m_core = (m_mode != M_RUN);
         if (m_mode == M_WAIT) begin
            if (ds) begin m_mode = M_HOLD; m_quiet = 0; end
         end else if (m_mode == M_HOLD) begin
            if (!ds) m_mode = M_WAIT;
            else if (cs) m_quiet = 0;
            else if (m_quiet == HC - 1) m_mode = M_RUN;
            else m_quiet++;
         end else begin
            if (!ds || cs) begin
               if (m_count < CMAX) m_count++;
               if (!ds) m_mode = M_WAIT;
               else begin m_mode = M_HOLD; m_quiet = 0; end
            end
         end
         for (int i = SS - 1; i > 0; i--) begin
            m_jp[i] = m_jp[i-1];
            m_dp[i] = m_dp[i-1];
         end
         m_jp[0] = jsys_reset;
         m_dp[0] = init_ddr3_done;
      end
   endtask

   // Advance one clock, compare all outputs to the model, return at the falling edge.
   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("core_reset",  core_reset,  m_core);
      chk("seq_state",   seq_state,   m_mode);
      chk("ddr_ready",   ddr_ready,   m_dp[SS-1]);
      chk("reset_count", reset_count, m_count);
      @(negedge clk);
   endtask

   task automatic wait_mode(input int target, input int budget, input string tag);
      for (int i = 0; i < budget && seq_state !== 2'(target); i++) cyc();
      chk(tag, seq_state, target);
   endtask

   task automatic edges_until_core(input logic val, input int budget, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (core_reset !== val && n < budget);
   endtask

   task automatic wait_quiet(input int q, input int budget, input string tag);
      for (int i = 0; i < budget && !(m_mode == M_HOLD && m_quiet == q); i++) cyc();
      chk(tag, (m_mode == M_HOLD && m_quiet == q), 1);
   endtask

   initial begin
      int n;
      int base;
      for (int i = 0; i < SS; i++) begin m_jp[i] = 1'b0; m_dp[i] = 1'b0; end

      // Power-up: reset low 4 cycles, DDR done at cycle 10
      repeat (4) cyc();
      chk("rst_core_reset", core_reset, 1);
      chk("rst_state", seq_state, M_WAIT);
      chk("rst_count", reset_count, 0);
      chk("rst_ddr_ready", ddr_ready, 0);
      rst_n = 1'b1;
      repeat (6) cyc();
      chk("wait_ddr_core_reset", core_reset, 1);
      init_ddr3_done = 1'b1;
      edges_until_core(1'b0, 60, n);
      chk("powerup_release_edges", n, SS + HC + 2);
      chk("powerup_state_run", seq_state, M_RUN);
      chk("powerup_count", reset_count, 0);

      // JTAG reset held 5 cycles while running
      repeat (3) cyc();
      jsys_reset = 1'b1;
      edges_until_core(1'b1, 20, n);
      chk("jtag_assert_edges", n, SS + 2);
      cyc();
      jsys_reset = 1'b0;
      edges_until_core(1'b0, 60, n);
      chk("jtag_release_edges", n, SS + HC + 1);
      chk("jtag_count", reset_count, 1);

      // Soft reset pulse during HOLD with hold_cnt at 3
      soft_reset_req = 1'b1;
      cyc();
      soft_reset_req = 1'b0;
      chk("soft_enter_hold", seq_state, M_HOLD);
      chk("soft_exit_count", reset_count, 2);
      wait_quiet(HC - 4, 40, "soft_reach_cnt3");
      chk("hold_cnt_before", dut.hold_cnt_q, 3);
      soft_reset_req = 1'b1;
      cyc();
      soft_reset_req = 1'b0;
      chk("hold_cnt_reload", dut.hold_cnt_q, HC - 1);
      chk("hold_soft_no_count", reset_count, 2);
      edges_until_core(1'b0, 60, n);
      chk("hold_soft_release_edges", n, HC + 1);

      // DDR loss coinciding with a soft request
      repeat (2) cyc();
      base = m_count;
      init_ddr3_done = 1'b0;
      cyc();
      cyc();
      chk("ddr_loss_ready", ddr_ready, 0);
      soft_reset_req = 1'b1;
      cyc();
      soft_reset_req = 1'b0;
      chk("ddr_loss_state", seq_state, M_WAIT);
      chk("ddr_loss_count", reset_count, base + 1);
      repeat (3) cyc();
      chk("ddr_loss_count_stable", reset_count, base + 1);
      init_ddr3_done = 1'b1;
      wait_mode(M_RUN, 60, "ddr_recover_run");

      // Saturation: 260 soft-driven exits from RUN
      base = m_count;
      for (int k = 1; k <= 260; k++) begin
         soft_reset_req = 1'b1;
         cyc();
         soft_reset_req = 1'b0;
         chk("sat_count", reset_count, (base + k > CMAX) ? CMAX : base + k);
         wait_mode(M_RUN, 40, "sat_back_to_run");
      end
      chk("sat_final", reset_count, CMAX);

      // Mid-sequence block reset with hold_cnt at 7
      soft_reset_req = 1'b1;
      cyc();
      soft_reset_req = 1'b0;
      wait_quiet(HC - 8, 40, "mid_reach_cnt7");
      chk("mid_hold_cnt", dut.hold_cnt_q, 7);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("mid_state", seq_state, M_WAIT);
      chk("mid_core_reset", core_reset, 1);
      chk("mid_count", reset_count, 0);
      chk("mid_ddr_ready", ddr_ready, 0);
      chk("mid_hold_cnt_clr", dut.hold_cnt_q, 0);
      cyc();
      chk("mid_ddr_ready_resync", ddr_ready, 0);
      chk("mid_still_wait", seq_state, M_WAIT);
      cyc();
      chk("mid_ddr_ready_back", ddr_ready, 1);
      wait_mode(M_RUN, 60, "mid_recover_run");

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(39, 0) == 0) jsys_reset = ~jsys_reset;
         if (init_ddr3_done) begin
            if ($urandom_range(149, 0) == 0) init_ddr3_done = 1'b0;
         end else if ($urandom_range(9, 0) == 0) begin
            init_ddr3_done = 1'b1;
         end
         soft_reset_req = ($urandom_range(24, 0) == 0);
         rst_n = ($urandom_range(399, 0) != 0);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
